// File: rtl/pc_flow_controller.sv
// pc_flow_controller
//   Control-flow sequencer for the program counter. Each cycle it turns the decoded
//   control-flow op, zero flag and interrupt request into pc_enable/pc_sel/target_addr.
//   It owns the hardware return-address stack (CALL/RET) and single-level interrupt
//   entry/exit.
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   stall, instr_valid       gate the cycle; when either blocks it, nothing moves
//   op, zero_flag            decoded control-flow op and ALU zero flag
//   branch_target, pc_in     decoded target and current PC
//   irq_req                  level interrupt request
//   pc_enable, pc_sel,
//   target_addr, irq_ack     combinational controls to the PC
//   in_isr, stack_overflow,
//   stack_underflow          registered status
module pc_flow_controller #(
  parameter int                ADDR_W      = 19,
  parameter int                STACK_DEPTH = 8,
  parameter logic [ADDR_W-1:0] IRQ_VECTOR  = 19'h00010
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              instr_valid,
  input  logic [2:0]        op,
  input  logic              zero_flag,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              irq_req,
  output logic              pc_enable,
  output logic [1:0]        pc_sel,
  output logic [ADDR_W-1:0] target_addr,
  output logic              irq_ack,
  output logic              in_isr,
  output logic              stack_overflow,
  output logic              stack_underflow
);

  localparam int IDX_W = $clog2(STACK_DEPTH);
  // sp needs one extra bit so that "full" (sp == STACK_DEPTH) is representable
  localparam int SP_W  = IDX_W + 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);
  localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);
  localparam logic [SP_W-1:0] SP_ZERO = SP_W'(0);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [SP_W-1:0]   sp_r, isr_sp_r, sp_m1_s;
  logic              in_isr_r, ovf_r, unf_r;
  logic [ADDR_W-1:0] stack_r [0:STACK_DEPTH-1];
  logic [ADDR_W-1:0] top_s, push_val_s;
  logic              full_s, empty_s;
  logic              push_s, pop_s, set_isr_s, clr_isr_s, set_ovf_s, set_unf_s;

  assign sp_m1_s = sp_r - SP_ONE;
  assign full_s  = (sp_r == SP_FULL);
  assign empty_s = (sp_r == SP_ZERO);
  assign top_s   = stack_r[sp_m1_s[IDX_W-1:0]];

  assign in_isr          = in_isr_r;
  assign stack_overflow  = ovf_r;
  assign stack_underflow = unf_r;

  // Next-state and PC control decode; interrupt entry pre-empts the current op
  always_comb begin
    pc_enable   = 1'b0;
    pc_sel      = 2'b00;
    target_addr = {ADDR_W{1'b0}};
    irq_ack     = 1'b0;
    state_nxt_s = state_r;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    push_val_s  = {ADDR_W{1'b0}};
    set_isr_s   = 1'b0;
    clr_isr_s   = 1'b0;
    set_ovf_s   = 1'b0;
    set_unf_s   = 1'b0;
    if (rst) begin
      pc_enable = 1'b0;
    end else if (state_r == ST_HALT) begin
      pc_enable = 1'b0;
    end else if (stall || !instr_valid) begin
      pc_enable = 1'b0;
    end else if (irq_req && !in_isr_r && !full_s) begin
      // Return address is the interrupted instruction itself: it was not executed
      pc_enable   = 1'b1;
      pc_sel      = 2'b11;
      target_addr = IRQ_VECTOR;
      irq_ack     = 1'b1;
      push_s      = 1'b1;
      push_val_s  = pc_in;
      set_isr_s   = 1'b1;
    end else begin
      pc_enable = 1'b1;
      case (op)
        3'b001: begin
          if (zero_flag) begin
            pc_sel      = 2'b01;
            target_addr = branch_target;
          end else begin
            pc_sel = 2'b00;
          end
        end
        3'b010: begin
          if (!zero_flag) begin
            pc_sel      = 2'b01;
            target_addr = branch_target;
          end else begin
            pc_sel = 2'b00;
          end
        end
        3'b011: begin
          pc_sel      = 2'b10;
          target_addr = branch_target;
        end
        3'b100: begin
          if (!full_s) begin
            pc_sel      = 2'b10;
            target_addr = branch_target;
            push_s      = 1'b1;
            push_val_s  = pc_in + ADDR_W'(1);
          end else begin
            pc_enable   = 1'b0;
            set_ovf_s   = 1'b1;
            state_nxt_s = ST_HALT;
          end
        end
        3'b101: begin
          if (!empty_s) begin
            pc_sel      = 2'b11;
            target_addr = top_s;
            pop_s       = 1'b1;
            // Popping the frame the interrupt pushed ends the handler
            if (in_isr_r && (sp_m1_s == isr_sp_r)) begin
              clr_isr_s = 1'b1;
            end else begin
              clr_isr_s = 1'b0;
            end
          end else begin
            pc_enable   = 1'b0;
            set_unf_s   = 1'b1;
            state_nxt_s = ST_HALT;
          end
        end
        default: begin
          pc_sel = 2'b00;
        end
      endcase
    end
  end

  // Control state: FSM, stack pointer, interrupt bookkeeping and sticky errors
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_RUN;
      sp_r     <= SP_ZERO;
      isr_sp_r <= SP_ZERO;
      in_isr_r <= 1'b0;
      ovf_r    <= 1'b0;
      unf_r    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (push_s) begin
        sp_r <= sp_r + SP_ONE;
      end else if (pop_s) begin
        sp_r <= sp_m1_s;
      end
      if (set_isr_s) begin
        in_isr_r <= 1'b1;
        isr_sp_r <= sp_r;
      end else if (clr_isr_s) begin
        in_isr_r <= 1'b0;
      end
      if (set_ovf_s) ovf_r <= 1'b1;
      if (set_unf_s) unf_r <= 1'b1;
    end
  end

  // Return-address storage; contents above sp are don't-care, so no reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      stack_r[sp_r[IDX_W-1:0]] <= push_val_s;
    end
  end

endmodule

// File: tb/tb_pc_flow_controller.sv
// Testbench for pc_flow_controller: directed scenarios plus randomized traffic,
// checked against a queue-based behavioural model of the return stack and ISR state.
module tb_pc_flow_controller;

  localparam int ADDR_W = 19;
  localparam int DEPTH  = 8;
  localparam logic [ADDR_W-1:0] IRQV = 19'h00010;

  logic              clk, rst, stall, instr_valid, zero_flag, irq_req;
  logic [2:0]        op;
  logic [ADDR_W-1:0] branch_target, pc_in, target_addr;
  logic              pc_enable, irq_ack, in_isr, stack_overflow, stack_underflow;
  logic [1:0]        pc_sel;

  pc_flow_controller #(.ADDR_W(ADDR_W), .STACK_DEPTH(DEPTH), .IRQ_VECTOR(IRQV)) dut (
    .clk(clk), .rst(rst), .stall(stall), .instr_valid(instr_valid), .op(op),
    .zero_flag(zero_flag), .branch_target(branch_target), .pc_in(pc_in),
    .irq_req(irq_req), .pc_enable(pc_enable), .pc_sel(pc_sel),
    .target_addr(target_addr), .irq_ack(irq_ack), .in_isr(in_isr),
    .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int unsigned rq[$];
  bit m_isr, m_halt, m_ovf, m_unf;
  int m_isr_depth;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_status();
    check_eq("in_isr", {31'd0, in_isr}, {31'd0, m_isr});
    check_eq("overflow", {31'd0, stack_overflow}, {31'd0, m_ovf});
    check_eq("underflow", {31'd0, stack_underflow}, {31'd0, m_unf});
  endtask

  task automatic model_clear();
    rq.delete();
    m_isr = 1'b0; m_halt = 1'b0; m_ovf = 1'b0; m_unf = 1'b0; m_isr_depth = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; irq_req = 1'b1; instr_valid = 1'b1; stall = 1'b0; op = 3'd4;
    #1;
    model_clear();
    check_eq("rst_en", {31'd0, pc_enable}, 32'd0);
    check_eq("rst_sel", {30'd0, pc_sel}, 32'd0);
    check_eq("rst_tgt", {13'd0, target_addr}, 32'd0);
    check_eq("rst_ack", {31'd0, irq_ack}, 32'd0);
    check_status();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One instruction cycle: drive, check combinational controls, clock, update model, check status
  task automatic cyc(input logic s, input logic v, input logic [2:0] o, input logic z,
                     input logic [ADDR_W-1:0] bt, input logic [ADDR_W-1:0] pc, input logic irq);
    logic e_en, e_ack;
    logic [1:0] e_sel;
    logic [ADDR_W-1:0] e_tgt;
    bit a_push, a_pop, a_seti, a_clri, a_ovf, a_unf;
    int unsigned a_val;
    stall = s; instr_valid = v; op = o; zero_flag = z; branch_target = bt; pc_in = pc;
    irq_req = irq;
    #1;
    e_en = 1'b0; e_sel = 2'b00; e_tgt = '0; e_ack = 1'b0;
    a_push = 0; a_pop = 0; a_seti = 0; a_clri = 0; a_ovf = 0; a_unf = 0; a_val = 0;
    if (!m_halt && !s && v) begin
      if (irq && !m_isr && rq.size() < DEPTH) begin
        e_en = 1; e_sel = 2'b11; e_tgt = IRQV; e_ack = 1;
        a_push = 1; a_val = pc; a_seti = 1;
      end else begin
        e_en = 1;
        case (o)
          3'd1: if (z)  begin e_sel = 2'b01; e_tgt = bt; end
          3'd2: if (!z) begin e_sel = 2'b01; e_tgt = bt; end
          3'd3: begin e_sel = 2'b10; e_tgt = bt; end
          3'd4: if (rq.size() < DEPTH) begin
                  e_sel = 2'b10; e_tgt = bt; a_push = 1;
                  a_val = (int'(pc) + 1) % (1 << ADDR_W);
                end else begin e_en = 0; a_ovf = 1; end
          3'd5: if (rq.size() > 0) begin
                  e_sel = 2'b11; e_tgt = rq[rq.size()-1]; a_pop = 1;
                  if (m_isr && (rq.size() - 1 == m_isr_depth)) a_clri = 1;
                end else begin e_en = 0; a_unf = 1; end
          default: e_sel = 2'b00;
        endcase
      end
    end
    check_eq("pc_enable", {31'd0, pc_enable}, {31'd0, e_en});
    check_eq("irq_ack", {31'd0, irq_ack}, {31'd0, e_ack});
    if (e_en) check_eq("pc_sel", {30'd0, pc_sel}, {30'd0, e_sel});
    if (e_en && e_sel != 2'b00) check_eq("target", {13'd0, target_addr}, {13'd0, e_tgt});
    @(posedge clk); #1;
    if (a_seti) begin m_isr_depth = rq.size(); m_isr = 1; end
    if (a_push) rq.push_back(a_val);
    if (a_pop) void'(rq.pop_back());
    if (a_clri) m_isr = 0;
    if (a_ovf) begin m_ovf = 1; m_halt = 1; end
    if (a_unf) begin m_unf = 1; m_halt = 1; end
    check_status();
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; instr_valid = 1'b0; op = 3'd0; zero_flag = 1'b0;
    branch_target = '0; pc_in = '0; irq_req = 1'b0;
    model_clear();
    do_reset();

    // 1: CALL then RET
    cyc(0, 1, 3'd4, 0, 19'h02000, 19'h00100, 0);
    cyc(0, 1, 3'd5, 0, 19'h00000, 19'h02000, 0);
    // 2: BEQ / BNE both zero values
    cyc(0, 1, 3'd1, 1, 19'h00400, 19'h00101, 0);
    cyc(0, 1, 3'd1, 0, 19'h00400, 19'h00101, 0);
    cyc(0, 1, 3'd2, 1, 19'h00400, 19'h00101, 0);
    cyc(0, 1, 3'd2, 0, 19'h00400, 19'h00101, 0);
    // 3: interrupt over JMP, second irq ignored, RET back
    cyc(0, 1, 3'd3, 0, 19'h03000, 19'h00050, 1);
    cyc(0, 1, 3'd0, 0, 19'h03000, 19'h00010, 1);
    cyc(0, 1, 3'd5, 0, 19'h00000, 19'h00011, 0);
    // 4: fill stack, irq deferred, overflow halts
    for (int i = 0; i < DEPTH; i++) cyc(0, 1, 3'd4, 0, 19'h01000 + 19'(i), 19'h00200 + 19'(i), 0);
    cyc(0, 1, 3'd0, 0, 19'h0, 19'h00300, 1);
    cyc(0, 1, 3'd4, 0, 19'h05000, 19'h00301, 0);
    cyc(0, 1, 3'd0, 0, 19'h0, 19'h00302, 0);
    cyc(0, 1, 3'd3, 0, 19'h00777, 19'h00303, 1);
    do_reset();
    // 5: underflow, then stall during CALL
    cyc(0, 1, 3'd5, 0, 19'h0, 19'h00400, 0);
    cyc(0, 1, 3'd0, 0, 19'h0, 19'h00401, 0);
    do_reset();
    cyc(1, 1, 3'd4, 0, 19'h06000, 19'h00500, 0);
    cyc(0, 0, 3'd4, 0, 19'h06000, 19'h00500, 1);
    cyc(0, 1, 3'd4, 0, 19'h06000, 19'h00500, 0);
    cyc(0, 1, 3'd5, 0, 19'h0, 19'h06000, 0);
    cyc(0, 1, 3'd5, 0, 19'h0, 19'h00501, 0);
    do_reset();
    // 6: wrap on return address, async reset mid-ISR
    cyc(0, 1, 3'd4, 0, 19'h00020, 19'h7FFFF, 0);
    cyc(0, 1, 3'd5, 0, 19'h0, 19'h00020, 0);
    cyc(0, 1, 3'd0, 0, 19'h0, 19'h00060, 1);
    stall = 1'b0; instr_valid = 1'b1; op = 3'd0; irq_req = 1'b0; #1;
    check_eq("isr_run_en", {31'd0, pc_enable}, 32'd1);
    #1 rst = 1'b1; #1;
    model_clear();
    check_eq("async_en", {31'd0, pc_enable}, 32'd0);
    check_status();
    @(posedge clk); #1 rst = 1'b0;
    cyc(0, 1, 3'd5, 0, 19'h0, 19'h00000, 0);
    do_reset();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (m_halt && ($urandom % 3 == 0)) begin
        do_reset();
      end else begin
        cyc(($urandom % 10) == 0, ($urandom % 10) != 0, 3'($urandom % 8), 1'($urandom % 2),
            19'($urandom), 19'($urandom), ($urandom % 6) == 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
